// File: rtl/rsa_mem_pkg.sv
// Shared types for the data-memory store buffer.
// Contents: bus widths, word-offset LSB, FSM state enum, pending-store entry struct.
package rsa_mem_pkg;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned WORD_LSB = 2;

  typedef enum logic {
    SB_RUN,
    SB_FLUSH
  } sb_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/mem_store_buffer_if.sv
// CPU-side and data_mem-side signals of the store buffer.
// slave  : the buffer (takes CPU requests and mem_rd, drives cpu_rd/stall/status and the mem port)
// master : the environment (pipeline MEM stage plus data_mem)
interface mem_store_buffer_if;
  import rsa_mem_pkg::*;

  logic              cpu_we;
  logic              cpu_re;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wd;
  logic [DATA_W-1:0] cpu_rd;
  logic              stall;
  logic              flush_req;
  logic              flush_done;
  logic              empty;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_a;
  logic [DATA_W-1:0] mem_wd;
  logic [DATA_W-1:0] mem_rd;

  modport slave (
    input  cpu_we, cpu_re, cpu_addr, cpu_wd, flush_req, mem_rd,
    output cpu_rd, stall, flush_done, empty, mem_we, mem_a, mem_wd
  );

  modport master (
    output cpu_we, cpu_re, cpu_addr, cpu_wd, flush_req, mem_rd,
    input  cpu_rd, stall, flush_done, empty, mem_we, mem_a, mem_wd
  );

endinterface

// File: rtl/sb_fwd_match.sv
// Store-to-load forwarding lookup: compares a word index against every pending
// entry and returns the data of the youngest valid hit.
// Ports: tags/datas (per-slot word index and data), valid (slot mask),
//        wr_ptr (next write slot), idx (lookup word index) -> hit, data.
module sb_fwd_match
  import rsa_mem_pkg::*;
#(
  parameter  int unsigned DEPTH  = 4,
  parameter  int unsigned IDX_HI = 13,
  localparam int unsigned PTR_W  = $clog2(DEPTH),
  localparam int unsigned IDX_W  = IDX_HI - WORD_LSB + 1
) (
  input  logic [IDX_W-1:0]  tags  [DEPTH],
  input  logic [DATA_W-1:0] datas [DEPTH],
  input  logic [DEPTH-1:0]  valid,
  input  logic [PTR_W-1:0]  wr_ptr,
  input  logic [IDX_W-1:0]  idx,
  output logic              hit,
  output logic [DATA_W-1:0] data
);

  logic [PTR_W-1:0] slot;

  // Walk oldest to youngest so a later (younger) hit overrides earlier ones.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    slot = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      slot = wr_ptr - PTR_W'(k);
      if (valid[slot] && (tags[slot] == idx)) begin
        hit  = 1'b1;
        data = datas[slot];
      end
    end
  end

endmodule

// File: rtl/mem_store_buffer.sv
// Posted-write buffer in front of data_mem. Stores retire into a FIFO in one
// cycle and drain on cycles with no CPU access; loads read data_mem directly
// with youngest-store forwarding; flush_req drains the FIFO and pulses flush_done.
// Ports: clk, reset (sync, active-low), sb (mem_store_buffer_if.slave: CPU
//        request/response, stall, flush handshake, empty, data_mem port).
module mem_store_buffer
  import rsa_mem_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned IDX_HI = 13
) (
  input logic             clk,
  input logic             reset,
  mem_store_buffer_if.slave sb
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned IDX_W = IDX_HI - WORD_LSB + 1;

  sb_entry_t         fifo_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  sb_state_t         state_q, state_d;

  logic              full, is_empty;
  logic              accept, drain_now, stall_c, flush_done_c;
  logic [DEPTH-1:0]  valid;
  logic [PTR_W-1:0]  off;
  logic [IDX_W-1:0]  tags  [DEPTH];
  logic [DATA_W-1:0] datas [DEPTH];
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign is_empty = (count_q == '0);

  // Slot i is pending when its distance from the head is below count.
  always_comb begin
    valid = '0;
    off   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off      = PTR_W'(i) - rd_ptr_q;
      valid[i] = ({1'b0, off} < count_q);
      tags[i]  = fifo_q[i].addr[IDX_HI:WORD_LSB];
      datas[i] = fifo_q[i].data;
    end
  end

  sb_fwd_match #(
    .DEPTH  (DEPTH),
    .IDX_HI (IDX_HI)
  ) u_fwd (
    .tags   (tags),
    .datas  (datas),
    .valid  (valid),
    .wr_ptr (wr_ptr_q),
    .idx    (sb.cpu_addr[IDX_HI:WORD_LSB]),
    .hit    (fwd_hit),
    .data   (fwd_data)
  );

  // Next state, accept/drain arbitration and stall.
  always_comb begin
    state_d      = state_q;
    accept       = 1'b0;
    drain_now    = 1'b0;
    stall_c      = 1'b0;
    flush_done_c = 1'b0;
    case (state_q)
      SB_RUN: begin
        accept    = sb.cpu_we && !full;
        stall_c   = sb.cpu_we && full;
        // A full-buffer store frees the head this cycle so it fits next cycle.
        drain_now = !is_empty && !sb.cpu_re && (!sb.cpu_we || full);
        if (sb.flush_req) state_d = SB_FLUSH;
      end
      SB_FLUSH: begin
        stall_c   = 1'b1;
        drain_now = !is_empty;
        if (is_empty) begin
          flush_done_c = 1'b1;
          state_d      = SB_RUN;
        end
      end
      default: state_d = SB_RUN;
    endcase
  end

  // State, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= SB_RUN;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept)    wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (drain_now) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({accept, drain_now})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage needs no reset; validity comes from the pointers and count.
  always_ff @(posedge clk) begin
    if (accept) fifo_q[wr_ptr_q] <= '{addr: sb.cpu_addr, data: sb.cpu_wd};
  end

  // data_mem port mux: head entry while draining, else pass the CPU access through.
  assign sb.mem_we     = drain_now;
  assign sb.mem_a      = drain_now ? fifo_q[rd_ptr_q].addr : sb.cpu_addr;
  assign sb.mem_wd     = drain_now ? fifo_q[rd_ptr_q].data : sb.cpu_wd;
  assign sb.stall      = stall_c;
  assign sb.flush_done = flush_done_c;
  assign sb.empty      = is_empty;
  assign sb.cpu_rd     = ((state_q == SB_RUN) && sb.cpu_re && !sb.cpu_we && fwd_hit)
                         ? fwd_data : sb.mem_rd;

endmodule
